// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes and execute-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative unsigned shift-add multiplier, one partial product
//               per cycle; done pulses with the full product on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             busy_q,  busy_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // {carry, hi, lo} shifts right once per step; lo starts as the multiplier
    always_comb begin
        step_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = CNT_LOAD;
            mcand_d = a;
            hi_d    = '0;
            lo_d    = b;
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign done    = busy_q && (cnt_q == '0);
    assign prod_lo = step_lo;
    assign prod_hi = step_hi;

endmodule : alu_mul_seq

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : Registered execute-stage ALU with valid/ready handshaking and
//               a backpressure-aware output stage. ALU_MULT_EN enables the
//               iterative MULT op (code 1000) through alu_mul_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow
);

    logic             accept;
    logic             is_mult;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             overflow_q,  overflow_d;

`ifdef ALU_MULT_EN
    alu_state_e       state_q, state_d;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;

    assign is_mult   = (Control == ALU_MULT);
    assign start_mul = accept && is_mult;
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
`else
    assign is_mult   = 1'b0;
    assign in_ready  = !out_valid_q || out_ready;
`endif

    assign accept = in_valid && in_ready;

    // Overflow rules: same-sign operands whose result flips sign; SUB sees ~B's sign
    always_comb begin
        sum     = A + B;
        diff    = A - B;
        add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        slt     = ($signed(A) < $signed(B));
    end

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        case (Control)
            ALU_AND: op_res = A & B;
            ALU_OR:  op_res = A | B;
            ALU_NOR: op_res = ~(A | B);
            ALU_ADD: begin
                op_res = sum;
                op_ovf = add_ovf;
            end
            ALU_SUB: begin
                op_res = diff;
                op_ovf = sub_ovf;
            end
            ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, slt};
            default: op_res = '0;
        endcase
    end

`ifdef ALU_MULT_EN
    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .prod_hi (mul_hi)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mul) state_d = MUL;
            MUL:     if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_hi_q <= '0;
        end else begin
            state_q     <= state_d;
            result_hi_q <= result_hi_d;
        end
    end

    assign ResultHi = result_hi_q;
`else
    assign ResultHi = '0;
`endif

    // Output stage holds until taken; a completion on the draining edge refills it
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
`ifdef ALU_MULT_EN
        result_hi_d = result_hi_q;
`endif
        if (accept && !is_mult) begin
            out_valid_d = 1'b1;
            result_d    = op_res;
            zero_d      = (op_res == '0);
            overflow_d  = op_ovf;
`ifdef ALU_MULT_EN
            result_hi_d = '0;
`endif
        end
`ifdef ALU_MULT_EN
        if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = mul_lo;
            result_hi_d = mul_hi;
            zero_d      = (mul_lo == '0);
            overflow_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = overflow_q;

endmodule : alu_exec

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module      : tb_alu_exec
// Description : Scoreboard bench for alu_exec; MULT scenarios need ALU_MULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   ctrl = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Result;
    logic [W-1:0] ResultHi;
    logic         Zero;
    logic         Overflow;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   rand_done = 1'b0;

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Control   (ctrl),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint s;
        logic [2*W-1:0] p;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (c)
            4'h0: e.res = x & y;
            4'h1: e.res = x | y;
            4'hC: e.res = ~(x | y);
            4'h2: begin
                s     = sx + sy;
                e.res = x + y;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'h6: begin
                s     = sx - sy;
                e.res = x - y;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'h7: e.res = (sx < sy) ? W'(1) : W'(0);
`ifdef ALU_MULT_EN
            4'h8: begin
                p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
            end
`endif
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Every output transfer is compared against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got Result=%h with no result expected", Result);
            end else begin
                mon_e = sb_q.pop_front();
                if ({Result, ResultHi, Zero, Overflow} !== {mon_e.res, mon_e.hi, mon_e.zero, mon_e.ovf}) begin
                    errors++;
                    $display("FAIL sb_result: got R=%h H=%h Z=%b V=%b, expected R=%h H=%h Z=%b V=%b",
                             Result, ResultHi, Zero, Overflow, mon_e.res, mon_e.hi, mon_e.zero, mon_e.ovf);
                end
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
        @(posedge clk); #1;
        in_valid = 1'b1;
        ctrl     = c;
        a        = x;
        b        = y;
        sb_q.push_back(model(c, x, y));
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        out_ready = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, Result, ResultHi, Zero, Overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b R=%h H=%h Z=%b V=%b, expected all 0",
                     out_valid, Result, ResultHi, Zero, Overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_add_overflow();
        int w;
        set_ready(1'b1);
        send(4'h2, 32'h7FFF_FFFF, 32'h1, w);
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, Result, Zero, Overflow} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got v=%b R=%h Z=%b V=%b, expected v=1 R=80000000 Z=0 V=1",
                     out_valid, Result, Zero, Overflow);
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3;
        send(4'h6, 32'h5, 32'h5, w1);
        send(4'h7, 32'h8000_0000, 32'h1, w2);
        checks++;
        if ({out_valid, Result, Zero} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_sub: got v=%b R=%h Z=%b, expected v=1 R=0 Z=1", out_valid, Result, Zero);
        end
        send(4'hC, 32'hFFFF_0000, 32'h0000_0F0F, w3);
        checks++;
        if ({Result, Overflow} !== {32'h1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_slt: got R=%h V=%b, expected R=1 V=0", Result, Overflow);
        end
        idle();
        @(negedge clk);
        checks++;
        if (Result !== 32'h0000_F0F0) begin
            errors++;
            $display("FAIL b2b_nor: got R=%h, expected 0000f0f0", Result);
        end
        checks++;
        if (w1 + w2 + w3 != 0) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d stall cycles, expected 0", w1 + w2 + w3);
        end
    endtask

    task automatic test_backpressure();
        int w;
        set_ready(1'b0);
        send(4'h1, 32'hF0, 32'h0F, w);
        @(posedge clk); #1;
        ctrl = 4'h0;
        a    = 32'h3;
        b    = 32'h6;
        sb_q.push_back(model(4'h0, 32'h3, 32'h6));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, Result} !== {1'b1, 1'b0, 32'hFF}) begin
                errors++;
                $display("FAIL bp_hold: got v=%b rdy=%b R=%h, expected v=1 rdy=0 R=ff",
                         out_valid, in_ready, Result);
            end
        end
        set_ready(1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b, expected 1", in_ready);
        end
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, Result} !== {1'b1, 32'h2}) begin
            errors++;
            $display("FAIL bp_second: got v=%b R=%h, expected v=1 R=2", out_valid, Result);
        end
    endtask

    task automatic test_unlisted();
        int w;
        logic [3:0] code;
        code = 4'hF;
        for (int k = 0; k < 2; k++) begin
`ifndef ALU_MULT_EN
            if (k == 1) code = 4'h8;
`endif
            send(code, 32'h3, 32'h4, w);
            idle();
            @(negedge clk);
            checks++;
            if ({out_valid, Result, ResultHi, Zero, Overflow} !== {1'b1, 32'h0, 32'h0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL unlisted_%h: got v=%b R=%h H=%h Z=%b V=%b, expected v=1 R=0 H=0 Z=1 V=0",
                         code, out_valid, Result, ResultHi, Zero, Overflow);
            end
        end
    endtask

`ifdef ALU_MULT_EN
    task automatic test_mult();
        int w;
        int busy_bad;
        send(4'h8, 32'hFFFF_FFFF, 32'h2, w);
        idle();
        ctrl     = 4'h2;
        busy_bad = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL mult_busy: got %0d cycles with in_ready/out_valid high, expected 0", busy_bad);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, ResultHi, Result, Overflow} !== {1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL mult_result: got v=%b H=%h R=%h V=%b, expected v=1 H=1 R=fffffffe V=0",
                     out_valid, ResultHi, Result, Overflow);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        int w;
`ifdef ALU_MULT_EN
        send(4'h8, 32'h1234_5678, 32'h9ABC_DEF0, w);
`else
        set_ready(1'b0);
        send(4'h1, 32'h1234_5678, 32'h9ABC_DEF0, w);
`endif
        idle();
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Result, ResultHi, Zero, Overflow} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b R=%h H=%h Z=%b V=%b, expected all 0",
                     out_valid, Result, ResultHi, Zero, Overflow);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b, expected 1", in_ready);
        end
        set_ready(1'b1);
        send(4'h0, 32'hC, 32'hA, w);
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, Result} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL midreset_and: got v=%b R=%h, expected v=1 R=8", out_valid, Result);
        end
    endtask

    task automatic test_random();
        logic [3:0] codes [8];
        int w;
        int n;
        codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'hF};
        rand_done = 1'b0;
        fork
            begin
                logic [W-1:0] x, y;
                for (int i = 0; i < 30; i++) begin
                    x = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : W'($urandom);
                    y = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : W'($urandom);
                    send(codes[$urandom_range(0, 7)], x, y, w);
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        set_ready(1'b1);
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_backpressure();
        test_unlisted();
`ifdef ALU_MULT_EN
        test_mult();
`endif
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_exec

`default_nettype wire
